sram_fifo_ctrl: RTL and testbench



---
 rtl/sram_fifo_ctrl_pkg.sv | 8 +
 rtl/sram_fifo_outbuf.sv | 58 +++++
 rtl/sram_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_sram_fifo_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_ctrl_pkg.sv
// Shared SRAM geometry for the 1rw1r 8x1024 macro and its clients.
package sram_fifo_ctrl_pkg;

  localparam int unsigned SRAM_DATA_WIDTH = 8;
  localparam int unsigned SRAM_ADDR_WIDTH = 10;
  localparam int unsigned SRAM_DEPTH      = 1 << SRAM_ADDR_WIDTH;

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry register FIFO that holds data captured from the SRAM read port.
// Entry 0 is always the head; the head keeps its last value once emptied.
module sram_fifo_outbuf
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_pop,
  output logic [1:0]            o_count,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [1:0]            r_count;
  logic [1:0]            w_count_next;
  logic [DATA_WIDTH-1:0] r_d0;
  logic [DATA_WIDTH-1:0] r_d1;

  // Occupancy next-state from push/pop.
  always_comb begin
    w_count_next = r_count;
    unique case ({i_push, i_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Entry storage: shift entry 1 forward on pop, land new data in the first free slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= 2'd0;
      r_d0    <= '0;
      r_d1    <= '0;
    end else begin
      r_count <= w_count_next;
      if (i_pop && (r_count == 2'd2)) begin
        r_d0 <= r_d1;
      end
      if (i_push) begin
        if ((r_count == 2'd0) || ((r_count == 2'd1) && i_pop)) begin
          r_d0 <= i_din;
        end else begin
          r_d1 <= i_din;
        end
      end
    end
  end

  assign o_count = r_count;
  assign o_valid = (r_count != 2'd0);
  assign o_head  = r_d0;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// Valid/ready byte FIFO backed by the 1rw1r OpenRAM macro, first-word-fall-through.
// Port 0 is used write-only for pushes, port 1 for pops; a 2-entry register buffer
// absorbs the macro's one-cycle read latency and X-after-hold output.
// Optional macro SRAM_FIFO_BYPASS_EN: pushes into an otherwise empty FIFO skip the SRAM.
module sram_fifo_ctrl
  import sram_fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SRAM_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = SRAM_ADDR_WIDTH,
  parameter int unsigned DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH+1:0] level,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic                  sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_scount;
  logic [ADDR_WIDTH:0]   w_scount_next;
  logic                  r_rd_pend;
  logic [ADDR_WIDTH+1:0] r_level;
  logic [ADDR_WIDTH+1:0] w_level_next;

  logic [1:0]            w_b;
  logic                  w_buf_valid;
  logic                  w_accept;
  logic                  w_pop;
  logic [2:0]            w_occ;
  logic                  w_issue;
  logic                  w_bypass;
  logic                  w_sram_wr;
  logic                  w_buf_push;
  logic [DATA_WIDTH-1:0] w_buf_din;

  assign in_ready  = (r_scount < LP_DEPTH);
  // Reset gating keeps both chip selects inactive the moment reset asserts.
  assign w_accept  = in_valid && in_ready && !reset;
  assign out_valid = w_buf_valid;
  assign w_pop     = w_buf_valid && out_ready;

  // Buffer occupancy after this edge, counting the read landing now; a new read
  // is only issued if its data will have a free slot next cycle.
  assign w_occ   = {1'b0, w_b} + {2'b00, r_rd_pend} - {2'b00, w_pop};
  assign w_issue = (r_scount != '0) && (w_occ < 3'd2) && !reset;

`ifdef SRAM_FIFO_BYPASS_EN
  assign w_bypass = w_accept && (r_scount == '0) && !r_rd_pend &&
                    (({1'b0, w_b} - {2'b00, w_pop}) < 3'd2);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_sram_wr  = w_accept && !w_bypass;
  // Bypass only fires with no read pending, so the two buffer sources never collide.
  assign w_buf_push = r_rd_pend || w_bypass;
  assign w_buf_din  = r_rd_pend ? sram_dout1 : in_data;

  assign sram_csb0   = !w_sram_wr;
  assign sram_web0   = 1'b0;
  assign sram_wmask0 = 1'b1;
  assign sram_addr0  = r_wr_ptr;
  assign sram_din0   = in_data;
  assign sram_csb1   = !w_issue;
  assign sram_addr1  = r_rd_ptr;
  assign level       = r_level;

  // SRAM residency and total-level next-state.
  always_comb begin
    w_scount_next = r_scount;
    w_level_next  = r_level;
    unique case ({w_sram_wr, w_issue})
      2'b10:   w_scount_next = r_scount + (ADDR_WIDTH + 1)'(1);
      2'b01:   w_scount_next = r_scount - (ADDR_WIDTH + 1)'(1);
      default: w_scount_next = r_scount;
    endcase
    unique case ({w_accept, w_pop})
      2'b10:   w_level_next = r_level + (ADDR_WIDTH + 2)'(1);
      2'b01:   w_level_next = r_level - (ADDR_WIDTH + 2)'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Pointer, count and read-pending state; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_scount  <= '0;
      r_rd_pend <= 1'b0;
      r_level   <= '0;
    end else begin
      if (w_sram_wr) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
      if (w_issue)   r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
      r_rd_pend <= w_issue;
      r_scount  <= w_scount_next;
      r_level   <= w_level_next;
    end
  end

  sram_fifo_outbuf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_outbuf (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_buf_push),
    .i_din   (w_buf_din),
    .i_pop   (w_pop),
    .o_count (w_b),
    .o_valid (w_buf_valid),
    .o_head  (out_data)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl with a behavioural 1rw1r SRAM model.
module tb_sram_fifo_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int LW    = AW + 2;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
  logic          sram_csb0, sram_web0, sram_wmask0, sram_csb1;
  logic [AW-1:0] sram_addr0, sram_addr1;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout1 = 'x;

  int errors = 0;
  int checks = 0;
  int n_acc  = 0;
  int n_pop  = 0;
  int coll   = 0;
  bit saw_wrap = 1'b0;
  bit any_wr = 1'b0;
  logic [AW-1:0] last_wr;
  logic [DW-1:0] q[$];
  logic [DW-1:0] sb_exp;

  sram_fifo_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .level       (level),
    .sram_csb0   (sram_csb0),
    .sram_web0   (sram_web0),
    .sram_wmask0 (sram_wmask0),
    .sram_addr0  (sram_addr0),
    .sram_din0   (sram_din0),
    .sram_csb1   (sram_csb1),
    .sram_addr1  (sram_addr1),
    .sram_dout1  (sram_dout1)
  );

  always #5 clk = ~clk;

  // SRAM model: inputs registered at posedge, read data driven at negedge, X after hold.
  logic [DW-1:0] mem [DEPTH];
  logic          rd_lat = 1'b0;
  logic [AW-1:0] rd_addr_lat;

  always @(posedge clk) begin
    if (sram_csb0 === 1'b0 && sram_web0 === 1'b0) mem[sram_addr0] <= sram_din0;
    rd_lat      <= (sram_csb1 === 1'b0);
    rd_addr_lat <= sram_addr1;
    if (sram_csb0 === 1'b0 && sram_csb1 === 1'b0 && sram_addr0 == sram_addr1) coll++;
    if (sram_csb0 === 1'b0) begin
      if (any_wr && last_wr == AW'(DEPTH - 1) && sram_addr0 == '0) saw_wrap = 1'b1;
      last_wr = sram_addr0;
      any_wr  = 1'b1;
    end
  end

  always @(posedge clk) begin
    #1 sram_dout1 = 'x;
  end

  always @(negedge clk) begin
    if (rd_lat) sram_dout1 = mem[rd_addr_lat];
  end

  // Scoreboard: record accepted pushes, check every pop against the oldest entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        n_pop++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL sb_pop: got out_data=%h, expected nothing (scoreboard empty)", out_data);
        end else begin
          sb_exp = q.pop_front();
          if (out_data !== sb_exp) begin
            errors++;
            $display("FAIL sb_pop: out_data=%h expected %h", out_data, sb_exp);
          end
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        q.push_back(in_data);
        n_acc++;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3000 && q.size() != 0; c++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: %b expected 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: %b expected 1", in_ready); end
    if (level !== '0) begin errors++; $display("FAIL rst_level: %0d expected 0", level); end
    if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL rst_csb0: %b expected 1", sram_csb0); end
    if (sram_csb1 !== 1'b1) begin errors++; $display("FAIL rst_csb1: %b expected 1", sram_csb1); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    out_ready = 1'b0;
    in_valid  = 1'b1;
`ifndef SRAM_FIFO_BYPASS_EN
    in_data = 8'hA5;
    #2;
    checks += 3;
    if (sram_csb0 !== 1'b0) begin errors++; $display("FAIL lat_csb0: %b expected 0", sram_csb0); end
    if (sram_addr0 !== '0) begin errors++; $display("FAIL lat_addr0: %0d expected 0", sram_addr0); end
    if (sram_din0 !== 8'hA5) begin errors++; $display("FAIL lat_din0: %h expected a5", sram_din0); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    checks += 3;
    if (sram_csb1 !== 1'b0) begin errors++; $display("FAIL lat_csb1: %b expected 0", sram_csb1); end
    if (sram_addr1 !== '0) begin errors++; $display("FAIL lat_addr1: %0d expected 0", sram_addr1); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid1: %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_early_valid2: %b expected 0", out_valid); end
    @(posedge clk); #1;
    checks += 3;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid: %b expected 1", out_valid); end
    if (out_data !== 8'hA5) begin errors++; $display("FAIL lat_data: %h expected a5", out_data); end
    if (level !== LW'(1)) begin errors++; $display("FAIL lat_level: %0d expected 1", level); end
`else
    in_data = 8'h3C;
    #2;
    checks++;
    if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL byp_csb0: %b expected 1", sram_csb0); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    checks += 4;
    if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL byp_csb0_idle: %b expected 1", sram_csb0); end
    if (out_valid !== 1'b1) begin errors++; $display("FAIL byp_valid: %b expected 1", out_valid); end
    if (out_data !== 8'h3C) begin errors++; $display("FAIL byp_data: %h expected 3c", out_data); end
    if (level !== LW'(1)) begin errors++; $display("FAIL byp_level: %0d expected 1", level); end
`endif
    drain();
    checks += 2;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_empty_valid: %b expected 0", out_valid); end
    if (level !== '0) begin errors++; $display("FAIL lat_empty_level: %0d expected 0", level); end
  endtask

  task automatic test_fill();
    int k = 0;
    bit acc;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int c = 0; c < 2000 && k < DEPTH + 2; c++) begin
      in_data = DW'(k);
      #2;
      acc = (in_ready === 1'b1);
      @(posedge clk); #1;
      if (acc) k++;
    end
    in_valid = 1'b0;
    #2;
    checks += 3;
    if (k != DEPTH + 2) begin errors++; $display("FAIL fill_accepts: %0d expected %0d", k, DEPTH + 2); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: %b expected 0", in_ready); end
    if (level !== LW'(DEPTH + 2)) begin errors++; $display("FAIL fill_level: %0d expected %0d", level, DEPTH + 2); end
    drain();
    checks += 2;
    if (q.size() != 0) begin errors++; $display("FAIL fill_drain: %0d left expected 0", q.size()); end
    if (level !== '0) begin errors++; $display("FAIL fill_drain_level: %0d expected 0", level); end
  endtask

  task automatic test_back_to_back();
    int p0 = n_pop;
    out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (n_pop - p0 != 256 - LAT) begin
      errors++;
      $display("FAIL stream_rate: %0d pops during stream expected %0d", n_pop - p0, 256 - LAT);
    end
    drain();
    checks++;
    if (n_pop - p0 != 256) begin errors++; $display("FAIL stream_total: %0d pops expected 256", n_pop - p0); end
  endtask

  task automatic test_random();
    int a0 = n_acc;
    for (int c = 0; c < 30000 && (n_acc - a0) < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk); #1;
      checks++;
      if (level !== LW'(q.size())) begin
        errors++;
        $display("FAIL rand_level: %0d expected %0d", level, q.size());
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_acc - a0 != 3000) begin errors++; $display("FAIL rand_accepts: %0d expected 3000", n_acc - a0); end
    drain();
    checks += 2;
    if (q.size() != 0) begin errors++; $display("FAIL rand_drain: %0d left expected 0", q.size()); end
    if (saw_wrap !== 1'b1) begin errors++; $display("FAIL rand_wrap: saw_wrap=%b expected 1", saw_wrap); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(8'h50 + i);
      @(posedge clk); #1;
    end
    checks++;
    if (level !== LW'(5)) begin errors++; $display("FAIL mid_level: %0d expected 5", level); end
    out_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks += 5;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: %b expected 0", out_valid); end
    if (level !== '0) begin errors++; $display("FAIL mid_rst_level: %0d expected 0", level); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: %b expected 1", in_ready); end
    if (sram_csb0 !== 1'b1) begin errors++; $display("FAIL mid_csb0: %b expected 1", sram_csb0); end
    if (sram_csb1 !== 1'b1) begin errors++; $display("FAIL mid_csb1: %b expected 1", sram_csb1); end
    q.delete();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h77;
    for (int c = 0; c < 4 && !found; c++) begin
      #2;
      if (sram_csb0 === 1'b0) begin
        found = 1'b1;
        checks++;
        if (sram_addr0 !== '0) begin errors++; $display("FAIL mid_addr0: %0d expected 0", sram_addr0); end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++;
    if (!found) begin errors++; $display("FAIL mid_write: csb0 never 0, expected an SRAM write"); end
    drain();
    checks++;
    if (level !== '0) begin errors++; $display("FAIL mid_drain_level: %0d expected 0", level); end
  endtask

  task automatic test_no_collision();
    checks++;
    if (coll !== 0) begin errors++; $display("FAIL collision: %0d same-address events expected 0", coll); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_fill();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_no_collision();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
